// File: rtl/core_mem_pkg.sv
// Shared types and defaults for the core-side memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // The data-streak counter is 4 bits wide, so MAX_DM_STREAK is limited to 1..15.
   localparam int STREAK_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_DM   = 2'd2
   } grant_t;

endpackage

// File: rtl/core_mem_arbiter.sv
// Shares one single-ported memory between the core fetch port and its load/store port.
// Latency: 2 cycles with a zero-wait memory (req -> mem_req -> ready); each mem_ack wait adds 1; issue interval 3.
// Backpressure: requesters hold req until their ready pulse; only one memory transaction is outstanding.
module core_mem_arbiter
   import core_mem_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   // load/store port
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_be,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ready,
   // memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
   localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

   state_t                state_q, state_d;
   grant_t                grant_q, grant_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;

   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [DATA_W/8-1:0]   mem_be_q, mem_be_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

   logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]     dm_rdata_q, dm_rdata_d;
   logic                  if_ready_q, if_ready_d;
   logic                  dm_ready_q, dm_ready_d;

   // Fetch wins when it is alone, or when data has already taken its maximum
   // run of grants while fetch was waiting.
   logic                  pick_if;
   assign pick_if = if_req && (!dm_req || (streak_q == STREAK_MAX));

   // Next-state logic: arbitration in IDLE, completion in BUSY, one-cycle ready in RESP.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      streak_d    = streak_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = if_ready_q;
      dm_ready_d  = dm_ready_q;

      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               mem_req_d = 1'b1;
               state_d   = BUSY;
               if (pick_if) begin
                  grant_d     = GNT_IF;
                  mem_we_d    = 1'b0;
                  mem_be_d    = '0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  streak_d    = '0;
               end else begin
                  grant_d     = GNT_DM;
                  mem_we_d    = dm_we;
                  mem_be_d    = dm_be;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  // Only grants that make fetch wait count toward the streak.
                  streak_d    = if_req ? (streak_q + STREAK_ONE) : '0;
               end
            end
         end

         BUSY: begin
            // Fields stay put until the memory acknowledges; a requester that
            // drops req here does not abort the transaction.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               if (grant_q == GNT_IF) begin
                  if_rdata_d = mem_rdata;
                  if_ready_d = 1'b1;
               end else if (grant_q == GNT_DM) begin
                  if (!mem_we_q) begin
                     dm_rdata_d = mem_rdata;
                  end
                  dm_ready_d = 1'b1;
               end
            end
         end

         RESP: begin
            // Requests are not looked at here, so a requester may retire or
            // change its request on the same edge it sees ready.
            if_ready_d = 1'b0;
            dm_ready_d = 1'b0;
            grant_d    = GNT_NONE;
            state_d    = IDLE;
         end

         default: begin
            state_d    = IDLE;
            grant_d    = GNT_NONE;
            mem_req_d  = 1'b0;
            if_ready_d = 1'b0;
            dm_ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= GNT_NONE;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         streak_q    <= streak_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ready  = if_ready_q;
   assign dm_ready  = dm_ready_q;

   // The two completion pulses never overlap.
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      !(if_ready_q && dm_ready_q));

   // While waiting for the memory, the request and its fields hold steady.
   a_busy_stable: assert property (@(posedge clk) disable iff (rst)
      (state_q == BUSY && !mem_ack) |=>
         (mem_req_q && $stable(mem_addr_q) && $stable(mem_we_q) &&
          $stable(mem_be_q) && $stable(mem_wdata_q)));

   // The streak never runs past its configured bound.
   a_streak_bound: assert property (@(posedge clk) disable iff (rst)
      streak_q <= STREAK_MAX);

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // ---------------- memory responder ----------------
   logic        auto_mem  = 1'b1;
   logic        use_fixed = 1'b0;
   logic        rand_wait = 1'b0;
   logic [31:0] fixed_rdata = '0;
   int          cur_wait = 0;
   int          wait_cnt = 0;

   always @(negedge clk) begin
      if (auto_mem) begin
         mem_ack = 1'b0;
         if (!mem_req) begin
            wait_cnt = 0;
         end else if (wait_cnt >= cur_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = use_fixed ? fixed_rdata : mem_word(mem_addr);
            wait_cnt  = 0;
            if (rand_wait) cur_wait = $urandom_range(0, 3);
         end else begin
            wait_cnt++;
         end
      end
   end

   // ---------------- transaction-level reference monitor ----------------
   logic        mon_en = 1'b0;
   logic        prev_mreq = 1'b0;
   logic        s_if = 1'b0, s_dm = 1'b0, s_we = 1'b0;
   logic [3:0]  s_be = '0;
   logic [31:0] s_ia = '0, s_da = '0, s_wd = '0;
   int          m_streak = 0;
   int          pend = 0;          // 0 none, 1 fetch, 2 data
   logic        pend_we = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [31:0] m_dm_rd = '0;
   logic        m_win_dm;

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_req && !prev_mreq) begin
            check("rnd_grant_has_req", s_if | s_dm, 1);
            check("rnd_no_overlap", pend, 0);
            m_win_dm = s_dm && !(s_if && m_streak == MAXS);
            if (m_win_dm) begin
               check("rnd_dm_we", mem_we, s_we);
               check("rnd_dm_be", mem_be, s_be);
               check("rnd_dm_addr", mem_addr, s_da);
               if (s_we) check("rnd_dm_wdata", mem_wdata, s_wd);
               m_streak  = s_if ? m_streak + 1 : 0;
               pend      = 2;
               pend_we   = s_we;
               pend_addr = s_da;
            end else begin
               check("rnd_if_we", mem_we, 0);
               check("rnd_if_be", mem_be, 0);
               check("rnd_if_addr", mem_addr, s_ia);
               m_streak  = 0;
               pend      = 1;
               pend_we   = 1'b0;
               pend_addr = s_ia;
            end
         end
         if (if_ready || dm_ready) begin
            check("rnd_ready_who", {if_ready, dm_ready},
                  (pend == 1) ? 32'd2 : (pend == 2) ? 32'd1 : 32'd0);
            if (pend == 1) begin
               check("rnd_if_rdata", if_rdata, mem_word(pend_addr));
            end else if (pend == 2) begin
               if (!pend_we) m_dm_rd = mem_word(pend_addr);
               check("rnd_dm_rdata", dm_rdata, m_dm_rd);
            end
            pend = 0;
         end
      end
      prev_mreq = mem_req;
      s_if = if_req; s_dm = dm_req; s_we = dm_we; s_be = dm_be;
      s_ia = if_addr; s_da = dm_addr; s_wd = dm_wdata;
   end

   // ---------------- random requesters ----------------
   task automatic if_agent(input int n);
      for (int k = 0; k < n; k++) begin
         int gap;
         logic got;
         logic [31:0] a;
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            if_req = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         a = $urandom; a[1:0] = 2'b00;
         if_addr = a;
         if_req  = 1'b1;
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            @(posedge clk); #1;
            if (if_ready) got = 1'b1;
         end
         check("rnd_if_done", got, 1);
      end
      if_req = 1'b0;
   endtask

   task automatic dm_agent(input int n);
      for (int k = 0; k < n; k++) begin
         int gap;
         logic got;
         logic [31:0] a;
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            dm_req = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         a = $urandom; a[1:0] = 2'b00;
         dm_addr  = a;
         dm_we    = 1'($urandom);
         dm_be    = 4'($urandom);
         dm_wdata = $urandom;
         dm_req   = 1'b1;
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            @(posedge clk); #1;
            if (dm_ready) got = 1'b1;
         end
         check("rnd_dm_done", got, 1);
      end
      dm_req = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        ifr, dmr, we;
      logic [3:0]  be;
      logic [31:0] ia, da, wd, rd;
      int          wt;
      logic        exp_if_win;
      logic [31:0] exp_if_rd, exp_dm_rd;
   } vec_t;

   function automatic vec_t mk(input logic ifr, input logic dmr, input logic we,
                               input logic [3:0] be, input logic [31:0] ia,
                               input logic [31:0] da, input logic [31:0] wd,
                               input logic [31:0] rd, input int wt, input logic ewin,
                               input logic [31:0] eir, input logic [31:0] edr);
      vec_t v;
      v.ifr = ifr; v.dmr = dmr; v.we = we; v.be = be; v.ia = ia; v.da = da;
      v.wd = wd; v.rd = rd; v.wt = wt; v.exp_if_win = ewin;
      v.exp_if_rd = eir; v.exp_dm_rd = edr;
      return v;
   endfunction

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int first_t, rdy_t, mcnt, nrdy;
      logic seen, got;
      logic [31:0] gseq;
      logic [31:0] gexp;

      rst = 1'b1;
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
      mem_rdata = 0; mem_ack = 0;
      repeat (3) @(negedge clk);
      check("rst_ctl", {mem_req, mem_we, mem_be, if_ready, dm_ready}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_dm_rdata", dm_rdata, 0);
      check("rst_ctl_after", {mem_req, if_ready, dm_ready}, 0);

      //            ifr  dmr  we  be       ia         da         wd            rd            wt ifwin  exp_if        exp_dm
      vecs[0] = mk(1'b1,1'b0,1'b0,4'h0,32'h00000010,32'h0,     32'h0,        32'h00100073, 0, 1'b1, 32'h00100073, 32'h0);
      vecs[1] = mk(1'b0,1'b1,1'b0,4'hF,32'h0,       32'h100,   32'h0,        32'hDEADBEEF, 3, 1'b0, 32'h00100073, 32'hDEADBEEF);
      vecs[2] = mk(1'b0,1'b1,1'b1,4'h3,32'h0,       32'h200,   32'h12345678, 32'hFFFFFFFF, 1, 1'b0, 32'h00100073, 32'hDEADBEEF);
      vecs[3] = mk(1'b1,1'b1,1'b0,4'hF,32'h14,      32'h300,   32'h0,        32'hCAFEF00D, 0, 1'b0, 32'h00100073, 32'hCAFEF00D);
      vecs[4] = mk(1'b1,1'b1,1'b1,4'hC,32'h14,      32'h304,   32'hA5A55A5A, 32'h77777777, 2, 1'b0, 32'h00100073, 32'hCAFEF00D);
      vecs[5] = mk(1'b1,1'b0,1'b0,4'h0,32'h18,      32'h0,     32'h0,        32'h11112222, 1, 1'b1, 32'h11112222, 32'hCAFEF00D);

      use_fixed = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         fixed_rdata = vecs[i].rd;
         cur_wait    = vecs[i].wt;
         if_addr = vecs[i].ia; dm_addr = vecs[i].da; dm_we = vecs[i].we;
         dm_be = vecs[i].be; dm_wdata = vecs[i].wd;
         if_req = vecs[i].ifr; dm_req = vecs[i].dmr;
         seen = 0; got = 0; first_t = -1; rdy_t = -1; mcnt = 0;
         for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (mem_req) begin
               mcnt++;
               if (!seen) begin
                  seen = 1; first_t = t;
                  if (vecs[i].exp_if_win) begin
                     check($sformatf("v%0d_we", i), mem_we, 0);
                     check($sformatf("v%0d_be", i), mem_be, 0);
                     check($sformatf("v%0d_addr", i), mem_addr, vecs[i].ia);
                  end else begin
                     check($sformatf("v%0d_we", i), mem_we, vecs[i].we);
                     check($sformatf("v%0d_be", i), mem_be, vecs[i].be);
                     check($sformatf("v%0d_addr", i), mem_addr, vecs[i].da);
                     if (vecs[i].we) check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wd);
                  end
               end
            end
            if (if_ready || dm_ready) begin
               got = 1; rdy_t = t;
               check($sformatf("v%0d_ready_who", i), {if_ready, dm_ready},
                     vecs[i].exp_if_win ? 32'd2 : 32'd1);
               check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_if_rd);
               check($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].exp_dm_rd);
               if_req = 0; dm_req = 0;
            end
         end
         check($sformatf("v%0d_mreq_cycle", i), first_t, 0);
         check($sformatf("v%0d_ready_cycle", i), rdy_t, vecs[i].wt + 1);
         check($sformatf("v%0d_mreq_len", i), mcnt, vecs[i].wt + 1);
         @(negedge clk);
         check($sformatf("v%0d_ready_one_cycle", i), {if_ready, dm_ready, mem_req}, 0);
      end
      use_fixed = 1'b0;

      // ---- reset in the middle of a transaction ----
      @(negedge clk);
      cur_wait = 20;
      dm_we = 0; dm_addr = 32'h400; dm_req = 1;
      repeat (3) @(negedge clk);
      check("rmid_busy", mem_req, 1);
      #2 rst = 1'b1;
      #1;
      check("rmid_ctl", {mem_req, mem_we, mem_be, if_ready, dm_ready}, 0);
      check("rmid_addr", mem_addr, 0);
      check("rmid_if_rdata", if_rdata, 0);
      check("rmid_dm_rdata", dm_rdata, 0);
      dm_req = 0;
      repeat (2) @(negedge clk);
      cur_wait = 0;
      rst = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         check("rmid_quiet", {mem_req, if_ready, dm_ready}, 0);
      end

      // ---- anti-starvation with both requesters held high ----
      @(negedge clk);
      if_addr = 32'h80; dm_addr = 32'h600; dm_we = 0; dm_be = 4'hF;
      if_req = 1; dm_req = 1;
      gexp = 32'b1000010000;   // grant n (bit n): 1 = fetch; D D D D I D D D D I
      gseq = '0;
      for (int g = 0; g < 10; g++) begin
         got = 0;
         for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (if_ready || dm_ready) begin
               got = 1;
               check("as_one_ready", if_ready & dm_ready, 0);
               gseq[g] = if_ready;
            end
         end
         check("as_grant_seen", got, 1);
      end
      check("as_grant_seq", gseq, gexp);
      if_req = 0; dm_req = 0;
      repeat (4) @(negedge clk);

      // ---- mem_ack in RESP and IDLE is ignored ----
      auto_mem = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      if_addr = 32'h40; if_req = 1;
      got = 0;
      for (int t = 0; t < 10 && !got; t++) begin
         @(negedge clk);
         if (mem_req) got = 1;
      end
      check("rb_mreq_seen", got, 1);
      mem_ack = 1; mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      check("rb_if_ready", {if_ready, dm_ready}, 2);
      check("rb_if_rdata", if_rdata, 32'h0BADF00D);
      if_req = 0; mem_rdata = 32'h33333333;
      @(negedge clk);
      check("rb_resp_ack", {mem_req, if_ready, dm_ready}, 0);
      check("rb_resp_rdata", if_rdata, 32'h0BADF00D);
      @(negedge clk);
      check("rb_idle_ack", {mem_req, if_ready, dm_ready}, 0);
      @(negedge clk);
      check("rb_idle_ack2", {mem_req, if_ready, dm_ready}, 0);
      mem_ack = 0;
      auto_mem = 1'b1;

      // ---- req dropped during BUSY still completes ----
      @(negedge clk);
      cur_wait = 2;
      dm_we = 0; dm_addr = 32'h500; dm_req = 1;
      got = 0;
      for (int t = 0; t < 10 && !got; t++) begin
         @(negedge clk);
         if (mem_req) got = 1;
      end
      check("drop_mreq_seen", got, 1);
      dm_req = 0;
      nrdy = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (dm_ready) nrdy++;
         if (if_ready) nrdy += 100;
      end
      check("drop_ready_count", nrdy, 1);
      check("drop_dm_rdata", dm_rdata, mem_word(32'h500));

      // ---- randomized traffic against the reference monitor ----
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_streak = 0; pend = 0; m_dm_rd = '0;
      rand_wait = 1'b1; cur_wait = 0;
      mon_en = 1'b1;
      @(posedge clk); #1;
      fork
         if_agent(40);
         dm_agent(40);
      join
      repeat (10) @(negedge clk);
      check("rnd_drained", pend, 0);
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
